up_int_ctrl: RTL and testbench

- Interrupt controller for the user plugin. Aggregates NUM_SRC peripheral interrupt sources (APB/AXI plugin blocks, upio edge events) into a single registered int_o toward the event unit.
- Provides per-source enable, edge/level type, pending, a claim/complete handshake, and fixed priority (lowest index wins).
- Configured through a flat APB slave port, decoded on a 12-bit address window inside the plugin APB region.

---
 rtl/up_int_ctrl_pkg.sv | 39 +++
 rtl/up_int_ctrl_if.sv | 23 ++
 rtl/up_int_prio_enc.sv | 24 ++
 rtl/up_int_ctrl.sv | 190 +++++++++++++++++++
 tb/tb_up_int_ctrl.sv | 260 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/up_int_ctrl_pkg.sv
// Shared definitions for the user-plugin interrupt controller:
// register word offsets (PADDR[4:2]), CLAIM word layout, claim response
// struct and the per-source trigger type.
package up_int_ctrl_pkg;

    // Register word offsets as decoded from PADDR[4:2]
    localparam logic [2:0] OFF_ENABLE    = 3'd0;  // 0x00
    localparam logic [2:0] OFF_TYPE      = 3'd1;  // 0x04
    localparam logic [2:0] OFF_PENDING   = 3'd2;  // 0x08
    localparam logic [2:0] OFF_CLAIM     = 3'd3;  // 0x0C
    localparam logic [2:0] OFF_COMPLETE  = 3'd4;  // 0x10
    localparam logic [2:0] OFF_INSERVICE = 3'd5;  // 0x14

    // CLAIM word: bit 31 = valid, low bits = source ID
    localparam int CLAIM_VALID_BIT = 31;
    localparam int CLAIM_ID_W      = 5;

    typedef struct packed {
        logic                  valid;
        logic [CLAIM_ID_W-1:0] id;
    } claim_resp_t;

    typedef enum logic {
        SRC_LEVEL = 1'b0,
        SRC_EDGE  = 1'b1
    } src_type_e;

    // Build the 32-bit CLAIM read word; an invalid claim reads as all zero
    function automatic logic [31:0] pack_claim(input claim_resp_t c);
        logic [31:0] word;
        word = '0;
        if (c.valid) begin
            word[CLAIM_VALID_BIT]  = 1'b1;
            word[CLAIM_ID_W-1:0]   = c.id;
        end
        return word;
    endfunction

endpackage

// File: rtl/up_int_ctrl_if.sv
// Flat APB3 bus bundle for the interrupt controller configuration port.
interface up_int_ctrl_if #(
    parameter int APB_ADDR_WIDTH = 12
);
    logic [APB_ADDR_WIDTH-1:0] PADDR;
    logic [31:0]               PWDATA;
    logic                      PWRITE;
    logic                      PSEL;
    logic                      PENABLE;
    logic [31:0]               PRDATA;
    logic                      PREADY;
    logic                      PSLVERR;

    modport master (
        output PADDR, PWDATA, PWRITE, PSEL, PENABLE,
        input  PRDATA, PREADY, PSLVERR
    );

    modport slave (
        input  PADDR, PWDATA, PWRITE, PSEL, PENABLE,
        output PRDATA, PREADY, PSLVERR
    );
endinterface

// File: rtl/up_int_prio_enc.sv
// Fixed-priority encoder: reports the lowest set index of i_req.
// o_id is 0 whenever o_valid is 0.
module up_int_prio_enc #(
    parameter int NUM_SRC = 8,
    parameter int ID_W    = 5
) (
    input  logic [NUM_SRC-1:0] i_req,
    output logic               o_valid,
    output logic [ID_W-1:0]    o_id
);

    // Scan from the top down so the lowest requesting index is the last write
    always_comb begin
        o_valid = 1'b0;
        o_id    = '0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (i_req[i]) begin
                o_valid = 1'b1;
                o_id    = ID_W'(i);
            end
        end
    end

endmodule

// File: rtl/up_int_ctrl.sv
// Interrupt controller for the user plugin. Collects NUM_SRC sources into
// one registered request (int_o) with per-source enable, edge/level type,
// pending, claim/complete and fixed lowest-index-wins priority.
// Optional macro UP_INT_CTRL_SYNC_EN inserts a 2-flop synchronizer on src_i
// (src_i to int_o latency becomes 4 cycles instead of 2).
module up_int_ctrl
    import up_int_ctrl_pkg::*;
#(
    parameter int NUM_SRC        = 8,
    parameter int APB_ADDR_WIDTH = 12,
    parameter int ID_W           = 5
) (
    input  logic               clk_i,
    input  logic               rst_n,
    up_int_ctrl_if.slave       apb,
    input  logic [NUM_SRC-1:0] src_i,
    output logic               int_o
);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [NUM_SRC-1:0] r_enable;
    logic [NUM_SRC-1:0] r_type;
    logic [NUM_SRC-1:0] r_pending;
    logic [NUM_SRC-1:0] r_inservice;
    logic [NUM_SRC-1:0] r_src_q;
    logic               r_int;

    // ------------------------------------------------------------------
    // Combinational nets
    // ------------------------------------------------------------------
    logic [NUM_SRC-1:0] w_src;
    logic [NUM_SRC-1:0] w_rise;
    logic [NUM_SRC-1:0] w_elig;
    logic [NUM_SRC-1:0] w_pending_next;
    logic [NUM_SRC-1:0] w_inservice_next;
    logic [NUM_SRC-1:0] w_w1c;
    logic [NUM_SRC-1:0] w_claim_onehot;
    logic [NUM_SRC-1:0] w_cmp_onehot;
    logic [2:0]         w_offset;
    logic               w_access;
    logic               w_unmapped;
    logic               w_wr;
    logic               w_rd;
    logic               w_claim_valid;
    logic [ID_W-1:0]    w_claim_id;
    logic               w_claim_fire;
    logic [ID_W-1:0]    w_cmp_id;
    logic               w_cmp_in_range;
    claim_resp_t        w_claim;
    logic [31:0]        w_prdata;
    logic               w_unused;

    // ------------------------------------------------------------------
    // Source conditioning
    // ------------------------------------------------------------------
`ifdef UP_INT_CTRL_SYNC_EN
    logic [NUM_SRC-1:0] r_sync1;
    logic [NUM_SRC-1:0] r_sync2;

    // Two-flop synchronizer for sources that are asynchronous to clk_i
    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= src_i;
            r_sync2 <= r_sync1;
        end
    end

    assign w_src = r_sync2;
`else
    assign w_src = src_i;
`endif

    // A source already high when reset releases is seen as a rising edge,
    // since r_src_q restarts at zero.
    assign w_rise = w_src & ~r_src_q;

    // ------------------------------------------------------------------
    // APB decode: single-cycle access, no wait states
    // ------------------------------------------------------------------
    assign w_offset   = apb.PADDR[4:2];
    assign w_access   = apb.PSEL & apb.PENABLE;
    assign w_unmapped = (w_offset > OFF_INSERVICE);
    assign w_wr       = w_access &  apb.PWRITE & ~w_unmapped;
    assign w_rd       = w_access & ~apb.PWRITE & ~w_unmapped;

    assign apb.PREADY  = 1'b1;
    assign apb.PSLVERR = w_access & w_unmapped;

    // ------------------------------------------------------------------
    // Eligibility and claim arbitration
    // ------------------------------------------------------------------
    assign w_elig = r_pending & r_enable & ~r_inservice;

    up_int_prio_enc #(
        .NUM_SRC (NUM_SRC),
        .ID_W    (ID_W)
    ) u_prio_enc (
        .i_req   (w_elig),
        .o_valid (w_claim_valid),
        .o_id    (w_claim_id)
    );

    assign w_claim.valid = w_claim_valid;
    assign w_claim.id    = w_claim_id;

    // A CLAIM read only has side effects when something was eligible
    assign w_claim_fire   = w_rd & (w_offset == OFF_CLAIM) & w_claim_valid;
    assign w_claim_onehot = w_claim_fire ? (NUM_SRC'(1) << w_claim_id) : '0;

    // W1C on PENDING only touches edge-typed bits
    assign w_w1c = (w_wr && (w_offset == OFF_PENDING))
                 ? (apb.PWDATA[NUM_SRC-1:0] & r_type) : '0;

    // COMPLETE with an out-of-range ID is silently dropped
    assign w_cmp_id       = apb.PWDATA[ID_W-1:0];
    assign w_cmp_in_range = (int'(w_cmp_id) < NUM_SRC);
    assign w_cmp_onehot   = (w_wr && (w_offset == OFF_COMPLETE) && w_cmp_in_range)
                          ? (NUM_SRC'(1) << w_cmp_id) : '0;

    // ------------------------------------------------------------------
    // Per-source pending update; a new edge wins over any clear
    // ------------------------------------------------------------------
    genvar gi;
    generate
        for (gi = 0; gi < NUM_SRC; gi++) begin : g_pend
            assign w_pending_next[gi] =
                (src_type_e'(r_type[gi]) == SRC_EDGE)
                ? (w_rise[gi] | (r_pending[gi] & ~w_w1c[gi] & ~w_claim_onehot[gi]))
                : r_src_q[gi];
        end
    endgenerate

    assign w_inservice_next = (r_inservice | w_claim_onehot) & ~w_cmp_onehot;

    // ------------------------------------------------------------------
    // Register file, sampled source and registered interrupt request
    // ------------------------------------------------------------------
    // Configuration and status registers, updated at the end of an access
    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            r_enable    <= '0;
            r_type      <= '0;
            r_pending   <= '0;
            r_inservice <= '0;
            r_src_q     <= '0;
            r_int       <= 1'b0;
        end else begin
            if (w_wr && (w_offset == OFF_ENABLE)) begin
                r_enable <= apb.PWDATA[NUM_SRC-1:0];
            end
            if (w_wr && (w_offset == OFF_TYPE)) begin
                r_type <= apb.PWDATA[NUM_SRC-1:0];
            end
            r_pending   <= w_pending_next;
            r_inservice <= w_inservice_next;
            r_src_q     <= w_src;
            r_int       <= |w_elig;
        end
    end

    assign int_o = r_int;

    // ------------------------------------------------------------------
    // Read mux; unmapped offsets and write-only COMPLETE read zero
    // ------------------------------------------------------------------
    // Combinational read data selected by word offset
    always_comb begin
        w_prdata = '0;
        case (w_offset)
            OFF_ENABLE:    w_prdata = 32'(r_enable);
            OFF_TYPE:      w_prdata = 32'(r_type);
            OFF_PENDING:   w_prdata = 32'(r_pending);
            OFF_CLAIM:     w_prdata = pack_claim(w_claim);
            OFF_INSERVICE: w_prdata = 32'(r_inservice);
            default:       w_prdata = '0;
        endcase
    end

    assign apb.PRDATA = w_prdata;

    // Address and data bits outside the decode window are intentionally ignored
    assign w_unused = &{1'b0, apb.PADDR[APB_ADDR_WIDTH-1:5], apb.PADDR[1:0],
                        apb.PWDATA[31:NUM_SRC]};

endmodule

// File: tb/tb_up_int_ctrl.sv
// Directed testbench for up_int_ctrl. Expected values are hand-derived
// from the register behaviour; LAT tracks the src_i-to-int_o latency of
// the build (2 by default, 4 with UP_INT_CTRL_SYNC_EN).
module tb_up_int_ctrl;

`ifdef UP_INT_CTRL_SYNC_EN
    localparam int LAT = 4;
`else
    localparam int LAT = 2;
`endif

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] src   = 8'h00;
    logic       int_o;

    int n_total = 0;
    int n_bad   = 0;

    up_int_ctrl_if #(.APB_ADDR_WIDTH(12)) apb ();

    up_int_ctrl #(
        .NUM_SRC        (8),
        .APB_ADDR_WIDTH (12),
        .ID_W           (5)
    ) dut (
        .clk_i (clk),
        .rst_n (rst_n),
        .apb   (apb),
        .src_i (src),
        .int_o (int_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp)
            $display("txn %-16s observed=%08h expected=%08h ok", tag, obs, exp);
        else begin
            n_bad++;
            $display("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
            $error("check %s", tag);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Called at posedge+1: setup phase, then access phase ending at next edge
    task automatic apb_write(input logic [11:0] addr, input logic [31:0] data);
        apb.PADDR   = addr;
        apb.PWDATA  = data;
        apb.PWRITE  = 1'b1;
        apb.PSEL    = 1'b1;
        apb.PENABLE = 1'b0;
        tick(1);
        apb.PENABLE = 1'b1;
        tick(1);
        apb.PSEL    = 1'b0;
        apb.PENABLE = 1'b0;
        apb.PWRITE  = 1'b0;
        $display("txn write addr=%03h data=%08h", addr, data);
    endtask

    task automatic apb_read(input logic [11:0] addr, output logic [31:0] data,
                            output logic err);
        apb.PADDR   = addr;
        apb.PWRITE  = 1'b0;
        apb.PSEL    = 1'b1;
        apb.PENABLE = 1'b0;
        tick(1);
        apb.PENABLE = 1'b1;
        #3;
        data = apb.PRDATA;
        err  = apb.PSLVERR;
        @(posedge clk);
        #1;
        apb.PSEL    = 1'b0;
        apb.PENABLE = 1'b0;
    endtask

    task automatic rd_chk(input string tag, input logic [11:0] addr, input logic [31:0] exp);
        logic [31:0] d;
        logic        e;
        apb_read(addr, d, e);
        chk(tag, d, exp);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] d;
        logic        e;

        apb.PADDR   = '0;
        apb.PWDATA  = '0;
        apb.PWRITE  = 1'b0;
        apb.PSEL    = 1'b0;
        apb.PENABLE = 1'b0;

        // ---------------- reset state ----------------
        tick(3);
        chk("rst_int", {31'b0, int_o}, 32'h0);
        rst_n = 1'b1;
        tick(1);
        rd_chk("rst_enable",    12'h000, 32'h0);
        rd_chk("rst_type",      12'h004, 32'h0);
        rd_chk("rst_pending",   12'h008, 32'h0);
        rd_chk("rst_claim",     12'h00C, 32'h0);
        rd_chk("rst_inservice", 12'h014, 32'h0);

        // ---------------- edge pulse, latency, claim ----------------
        apb_write(12'h000, 32'h05);
        apb_write(12'h004, 32'h01);
        src[0] = 1'b1;
        tick(1);
        src[0] = 1'b0;
        tick(LAT - 2);
        chk("lat_int_early", {31'b0, int_o}, 32'h0);
        tick(1);
        chk("lat_int_on", {31'b0, int_o}, 32'h1);
        rd_chk("t1_pending", 12'h008, 32'h01);
        rd_chk("t1_claim",   12'h00C, 32'h8000_0000);
        tick(1);
        chk("t1_int_off", {31'b0, int_o}, 32'h0);
        rd_chk("t1_inservice", 12'h014, 32'h01);
        rd_chk("t1_pend_clr",  12'h008, 32'h00);

        // ---------------- priority and level re-assert ----------------
        apb_write(12'h010, 32'h0);
        src[2] = 1'b1;
        src[0] = 1'b1;
        tick(1);
        src[0] = 1'b0;
        tick(LAT + 1);
        chk("t2_int_on", {31'b0, int_o}, 32'h1);
        rd_chk("t2_claim0", 12'h00C, 32'h8000_0000);
        rd_chk("t2_claim2", 12'h00C, 32'h8000_0002);
        tick(1);
        chk("t2_int_off", {31'b0, int_o}, 32'h0);
        apb_write(12'h010, 32'h2);
        chk("t2_int_cmp", {31'b0, int_o}, 32'h0);
        tick(1);
        chk("t2_int_rearm", {31'b0, int_o}, 32'h1);
        rd_chk("t2_insvc", 12'h014, 32'h01);
        rd_chk("t2_reclaim2", 12'h00C, 32'h8000_0002);
        src[2] = 1'b0;
        tick(LAT);
        apb_write(12'h010, 32'h2);
        tick(1);
        chk("t2_int_done", {31'b0, int_o}, 32'h0);
        apb_write(12'h010, 32'h0);
        rd_chk("t2_insvc_clr", 12'h014, 32'h00);

        // ---------------- edge beats W1C, COMPLETE out of range ----------------
        src[0] = 1'b1;
        tick(1);
        src[0] = 1'b0;
        tick(LAT + 1);
        if (LAT == 2) begin
            apb.PADDR = 12'h008; apb.PWDATA = 32'h1; apb.PWRITE = 1'b1;
            apb.PSEL  = 1'b1;    apb.PENABLE = 1'b0;
            tick(1);
            apb.PENABLE = 1'b1;
            src[0] = 1'b1;
            tick(1);
        end else begin
            src[0] = 1'b1;
            tick(1);
            apb.PADDR = 12'h008; apb.PWDATA = 32'h1; apb.PWRITE = 1'b1;
            apb.PSEL  = 1'b1;    apb.PENABLE = 1'b0;
            tick(1);
            apb.PENABLE = 1'b1;
            tick(1);
        end
        apb.PSEL = 1'b0; apb.PENABLE = 1'b0; apb.PWRITE = 1'b0;
        $display("txn write addr=008 data=00000001 (with coincident edge)");
        src[0] = 1'b0;
        tick(LAT + 1);
        rd_chk("t3_edge_wins", 12'h008, 32'h01);
        apb_write(12'h008, 32'h01);
        rd_chk("t3_w1c", 12'h008, 32'h00);
        src[0] = 1'b1;
        tick(1);
        src[0] = 1'b0;
        tick(LAT + 1);
        rd_chk("t3_claim0", 12'h00C, 32'h8000_0000);
        apb_write(12'h010, 32'h8);
        rd_chk("t3_cmp_oor", 12'h014, 32'h01);
        apb_write(12'h010, 32'h0);
        rd_chk("t3_cmp0", 12'h014, 32'h00);

        // ---------------- disabled sources, empty claim, PSLVERR ----------------
        apb_write(12'h000, 32'h00);
        src[1] = 1'b1;
        src[0] = 1'b1;
        tick(1);
        src[0] = 1'b0;
        tick(LAT + 2);
        chk("t4_int_dis", {31'b0, int_o}, 32'h0);
        rd_chk("t4_claim_none", 12'h00C, 32'h0);
        rd_chk("t4_pending",    12'h008, 32'h03);
        rd_chk("t4_insvc",      12'h014, 32'h00);
        apb_read(12'h018, d, e);
        chk("t4_slverr", {31'b0, e}, 32'h1);
        chk("t4_slv_data", d, 32'h0);
        apb_read(12'h000, d, e);
        chk("t4_no_slverr", {31'b0, e}, 32'h0);
        apb_write(12'h000, 32'h03);
        chk("t4_int_pre", {31'b0, int_o}, 32'h0);
        tick(1);
        chk("t4_int_en", {31'b0, int_o}, 32'h1);

        // ---------------- async reset mid-claim ----------------
        src[1] = 1'b0;
        src[2] = 1'b1;
        apb_write(12'h000, 32'h04);
        tick(LAT + 2);
        chk("t5_int_on", {31'b0, int_o}, 32'h1);
        rd_chk("t5_claim2", 12'h00C, 32'h8000_0002);
        apb_write(12'h000, 32'h05);
        tick(1);
        chk("t5_int_pend0", {31'b0, int_o}, 32'h1);
        rd_chk("t5_insvc", 12'h014, 32'h04);
        apb.PADDR = 12'h00C; apb.PWRITE = 1'b0; apb.PSEL = 1'b1; apb.PENABLE = 1'b0;
        tick(1);
        apb.PENABLE = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        chk("t5_rst_int", {31'b0, int_o}, 32'h0);
        apb.PSEL = 1'b0; apb.PENABLE = 1'b0;
        apb.PADDR = 12'h000; #1;
        chk("t5_rst_enable", apb.PRDATA, 32'h0);
        apb.PADDR = 12'h008; #1;
        chk("t5_rst_pending", apb.PRDATA, 32'h0);
        apb.PADDR = 12'h014; #1;
        chk("t5_rst_insvc", apb.PRDATA, 32'h0);
        apb.PADDR = 12'h00C; #1;
        chk("t5_rst_claim", apb.PRDATA, 32'h0);
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        tick(4);
        rd_chk("t5_lvl_pend", 12'h008, 32'h04);
        rd_chk("t5_enable",   12'h000, 32'h00);
        chk("t5_int_after", {31'b0, int_o}, 32'h0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
